// File: rtl/im_load_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : im_load_run_ctrl
// Description : Host load/run controller. Streams host words into IM,
//               releases the core, reports retires and signals completion.
// Revision    : 1.0 - initial release
// ============================================================================
module im_load_run_ctrl #(
    parameter int          IM_DEPTH   = 10,
    parameter logic [31:0] END_INST   = 32'h0000_0073,
    parameter int          MAX_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_im,
    input  logic [31:0]         top_inst_i,
    input  logic                start,
    output logic                finish,
    output logic [31:0]         executed_inst,
    output logic                timeout,
    output logic                load_ovf,
    output logic                im_we,
    output logic [IM_DEPTH-1:0] im_waddr,
    output logic [31:0]         im_wdata,
    output logic                cpu_run,
    input  logic                wb_valid,
    input  logic [31:0]         wb_inst
);

    localparam int                c_CYC_W   = $clog2(MAX_CYCLES + 1);
    localparam logic [c_CYC_W-1:0] c_MAX_CYC = c_CYC_W'(MAX_CYCLES);
    localparam logic [IM_DEPTH:0] c_IM_CAP  = {1'b1, {IM_DEPTH{1'b0}}};
    localparam logic [IM_DEPTH:0] c_CNT_ONE = {{IM_DEPTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IM_DEPTH:0]    r_load_cnt;
    logic [IM_DEPTH:0]    r_ret_cnt;
    logic [c_CYC_W-1:0]   r_cyc_cnt;
    logic                 r_im_we;
    logic [IM_DEPTH-1:0]  r_im_waddr;
    logic [31:0]          r_im_wdata;
    logic [31:0]          r_exec;
    logic                 r_timeout;
    logic                 r_load_ovf;

    logic w_im_full;
    logic w_load_ok;
    logic w_load_drop;
    logic w_retire;
    logic w_ret_last;
    logic w_wdog;

    assign w_im_full   = (r_load_cnt == c_IM_CAP);
    assign w_load_ok   = (r_state == ST_LOAD) && wr_im && !w_im_full;
    assign w_load_drop = (r_state == ST_LOAD) && wr_im && w_im_full;
    assign w_retire    = (r_state == ST_RUN) && wb_valid;
    // The last loaded word retiring ends the run even without END_INST.
    assign w_ret_last  = w_retire &&
                         ((wb_inst == END_INST) || ((r_ret_cnt + c_CNT_ONE) == r_load_cnt));
    assign w_wdog      = (r_state == ST_RUN) && (r_cyc_cnt == c_MAX_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (start && !wr_im) begin
                    w_state_nxt = (r_load_cnt == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_ret_last || w_wdog) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt <= '0;
            r_ret_cnt  <= '0;
            r_cyc_cnt  <= '0;
            r_im_we    <= 1'b0;
            r_im_waddr <= '0;
            r_im_wdata <= '0;
            r_exec     <= '0;
            r_timeout  <= 1'b0;
            r_load_ovf <= 1'b0;
        end else begin
            r_im_we <= w_load_ok;
            if (w_load_ok) begin
                r_im_waddr <= r_load_cnt[IM_DEPTH-1:0];
                r_im_wdata <= top_inst_i;
                r_load_cnt <= r_load_cnt + c_CNT_ONE;
            end
            if (w_load_drop) begin
                r_load_ovf <= 1'b1;
            end
            r_exec <= w_retire ? wb_inst : 32'h0;
            if (w_retire) begin
                r_ret_cnt <= r_ret_cnt + c_CNT_ONE;
            end
            if ((r_state == ST_RUN) && !w_wdog) begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end
            if (w_wdog) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign finish        = (r_state == ST_DONE);
    assign cpu_run       = (r_state == ST_RUN);
    assign executed_inst = r_exec;
    assign timeout       = r_timeout;
    assign load_ovf      = r_load_ovf;
    assign im_we         = r_im_we;
    assign im_waddr      = r_im_waddr;
    assign im_wdata      = r_im_wdata;

endmodule
`default_nettype wire

// File: tb/tb_im_load_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_load_run_ctrl
// Description : Scoreboard bench for im_load_run_ctrl (default and small IM).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_load_run_ctrl;

    localparam int c_B_DEPTH = 2;
    localparam int c_B_MAXC  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_wr_im, a_start, a_wb_valid;
    logic [31:0] a_inst, a_wb_inst;
    logic        a_finish, a_timeout, a_load_ovf, a_im_we, a_cpu_run;
    logic [31:0] a_exec, a_im_wdata;
    logic [9:0]  a_im_waddr;

    logic        b_wr_im, b_start, b_wb_valid;
    logic [31:0] b_inst, b_wb_inst;
    logic        b_finish, b_timeout, b_load_ovf, b_im_we, b_cpu_run;
    logic [31:0] b_exec, b_im_wdata;
    logic [c_B_DEPTH-1:0] b_im_waddr;

    im_load_run_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .wr_im(a_wr_im), .top_inst_i(a_inst), .start(a_start),
        .finish(a_finish), .executed_inst(a_exec), .timeout(a_timeout), .load_ovf(a_load_ovf),
        .im_we(a_im_we), .im_waddr(a_im_waddr), .im_wdata(a_im_wdata), .cpu_run(a_cpu_run),
        .wb_valid(a_wb_valid), .wb_inst(a_wb_inst)
    );

    im_load_run_ctrl #(.IM_DEPTH(c_B_DEPTH), .MAX_CYCLES(c_B_MAXC)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_im(b_wr_im), .top_inst_i(b_inst), .start(b_start),
        .finish(b_finish), .executed_inst(b_exec), .timeout(b_timeout), .load_ovf(b_load_ovf),
        .im_we(b_im_we), .im_waddr(b_im_waddr), .im_wdata(b_im_wdata), .cpu_run(b_cpu_run),
        .wb_valid(b_wb_valid), .wb_inst(b_wb_inst)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [41:0] a_wq [$];
    logic [31:0] a_rq [$];
    logic [33:0] b_wq [$];
    logic [31:0] a_prog [0:7];
    logic [41:0] a_we_e;
    logic [31:0] a_rt_e;
    logic [33:0] b_we_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Output monitors: IM writes and retires are popped from the scoreboards.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_im_we) begin
                chk("a_we_expected", 32'(a_wq.size() != 0), 32'd1);
                if (a_wq.size() != 0) begin
                    a_we_e = a_wq.pop_front();
                    chk("a_waddr", 32'(a_im_waddr), 32'(a_we_e[41:32]));
                    chk("a_wdata", a_im_wdata, a_we_e[31:0]);
                end
            end
            if (a_exec != 32'h0) begin
                chk("a_retire_expected", 32'(a_rq.size() != 0), 32'd1);
                if (a_rq.size() != 0) begin
                    a_rt_e = a_rq.pop_front();
                    chk("a_executed_inst", a_exec, a_rt_e);
                end
            end
            if (b_im_we) begin
                chk("b_we_expected", 32'(b_wq.size() != 0), 32'd1);
                if (b_wq.size() != 0) begin
                    b_we_e = b_wq.pop_front();
                    chk("b_waddr", 32'(b_im_waddr), 32'(b_we_e[33:32]));
                    chk("b_wdata", b_im_wdata, b_we_e[31:0]);
                end
            end
            if (b_exec != 32'h0) begin
                chk("b_exec_idle", b_exec, 32'h0);
            end
        end
    end

    task automatic clear_inputs();
        a_wr_im = 0; a_start = 0; a_wb_valid = 0; a_inst = 0; a_wb_inst = 0;
        b_wr_im = 0; b_start = 0; b_wb_valid = 0; b_inst = 0; b_wb_inst = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Loads a_prog[0..n-1]; the controller is assumed freshly reset.
    task automatic a_load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_wr_im = 1'b1;
            a_inst  = a_prog[i];
            a_wq.push_back({10'(i), a_prog[i]});
        end
        @(negedge clk);
        a_wr_im = 1'b0;
        chk("a_no_ovf", 32'(a_load_ovf), 32'd0);
    endtask

    // Starts the run and retires n words back to back; the n-th must terminate.
    task automatic a_run(input int n);
        @(negedge clk);
        a_start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_start = 1'b0;
            chk("a_cpu_run", 32'(a_cpu_run), 32'd1);
            a_wb_valid = 1'b1;
            a_wb_inst  = a_prog[i];
            a_rq.push_back(a_prog[i]);
        end
        @(negedge clk);
        a_wb_valid = 1'b0;
        chk("a_drain_finish", 32'(a_finish), 32'd0);
        chk("a_drain_cpu_run", 32'(a_cpu_run), 32'd0);
        @(negedge clk);
        chk("a_finish", 32'(a_finish), 32'd1);
        chk("a_timeout", 32'(a_timeout), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk("rst_finish", 32'(a_finish), 32'd0);
        chk("rst_exec", a_exec, 32'd0);
        chk("rst_timeout", 32'(a_timeout), 32'd0);
        chk("rst_load_ovf", 32'(a_load_ovf), 32'd0);
        chk("rst_im_we", 32'(a_im_we), 32'd0);
        chk("rst_im_waddr", 32'(a_im_waddr), 32'd0);
        chk("rst_im_wdata", a_im_wdata, 32'd0);
        chk("rst_cpu_run", 32'(a_cpu_run), 32'd0);
        rst_n = 1'b1;

        // Small IM: overflow, start ignored alongside wr_im, then watchdog.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b_load_ovf_step", 32'(b_load_ovf), 32'(k >= 5));
            b_wr_im = 1'b1;
            b_inst  = 32'hB000_0000 + 32'(k);
            b_start = (k == 5);
            if (k < 4) b_wq.push_back({2'(k), 32'hB000_0000 + 32'(k)});
        end
        @(negedge clk);
        b_wr_im = 1'b0;
        b_start = 1'b0;
        chk("b_load_ovf", 32'(b_load_ovf), 32'd1);
        chk("b_start_ignored", 32'(b_cpu_run), 32'd0);
        chk("b_start_ignored_fin", 32'(b_finish), 32'd0);
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        chk("b_cpu_run", 32'(b_cpu_run), 32'd1);
        repeat (17) @(posedge clk);
        #1;
        chk("b_finish_early", 32'(b_finish), 32'd0);
        @(posedge clk);
        #1;
        chk("b_finish_wdog", 32'(b_finish), 32'd1);
        chk("b_timeout", 32'(b_timeout), 32'd1);
        chk("b_cpu_run_done", 32'(b_cpu_run), 32'd0);

        // Five-word program ending in END_INST.
        do_reset();
        a_prog[0] = 32'h0050_0093; a_prog[1] = 32'h0010_8133; a_prog[2] = 32'h0020_81b3;
        a_prog[3] = 32'h0000_0013; a_prog[4] = 32'h0000_0073;
        a_load(5);
        a_run(5);
        @(negedge clk);
        a_wr_im = 1'b1; a_inst = 32'hDEAD_BEEF; a_start = 1'b1;
        @(negedge clk);
        a_wr_im = 1'b0; a_start = 1'b0;
        chk("a_done_no_we", 32'(a_im_we), 32'd0);
        chk("a_done_sticky", 32'(a_finish), 32'd1);
        chk("a_done_exec", a_exec, 32'd0);

        // Three NOPs: termination by retire count.
        do_reset();
        a_prog[0] = 32'h0000_0013; a_prog[1] = 32'h0000_0013; a_prog[2] = 32'h0000_0013;
        a_load(3);
        a_run(3);

        // END_INST retiring before the last loaded word.
        do_reset();
        a_prog[0] = 32'h0000_0013; a_prog[1] = 32'h0000_0073; a_prog[2] = 32'h0000_0013;
        a_load(3);
        a_run(2);

        // Empty program goes straight through DRAIN.
        do_reset();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("empty_cpu_run", 32'(a_cpu_run), 32'd0);
        chk("empty_drain", 32'(a_finish), 32'd0);
        @(negedge clk);
        chk("empty_finish", 32'(a_finish), 32'd1);
        chk("empty_cpu_run2", 32'(a_cpu_run), 32'd0);

        // Reset in the middle of a run, then reload and complete.
        do_reset();
        a_prog[0] = 32'h0010_0093; a_prog[1] = 32'h0020_0113;
        a_load(2);
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_wb_valid = 1'b1;
        a_wb_inst = a_prog[0];
        @(posedge clk);
        #1;
        chk("mid_exec", a_exec, 32'h0010_0093);
        chk("mid_cpu_run", 32'(a_cpu_run), 32'd1);
        rst_n = 1'b0;
        a_wb_valid = 1'b0;
        #1;
        chk("mid_rst_cpu_run", 32'(a_cpu_run), 32'd0);
        chk("mid_rst_finish", 32'(a_finish), 32'd0);
        chk("mid_rst_exec", a_exec, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_prog[0] = 32'h0000_0013;
        a_load(1);
        a_run(1);

        repeat (2) @(negedge clk);
        chk("a_wq_drained", 32'(a_wq.size()), 32'd0);
        chk("a_rq_drained", 32'(a_rq.size()), 32'd0);
        chk("b_wq_drained", 32'(b_wq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
